// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serial transmitter.
// Optional feature macro: PISO_PARITY_EN (appends one even-parity bit per frame).
package piso_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

`ifdef PISO_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  // Bit counter width; wide enough to hold the word width itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Serial frame length: data bits plus the optional parity bit.
  function automatic int unsigned frame_len(input int unsigned n);
    return ParityEn ? n + 1 : n;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter with clear/increment and a last-bit comparator.
// Optional feature macro: PISO_PARITY_EN (only affects the LastVal the top passes in).
module piso_bit_counter #(
  parameter int unsigned Width   = 3,
  parameter int unsigned LastVal = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count,
  output logic             last
);

  localparam logic [Width-1:0] LastCnt = Width'(LastVal);

  assign last = (count == LastCnt);

  // Counter register; clear has priority so the count never runs past the frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, LSB first, with valid/ready word load.
// Optional feature macro: PISO_PARITY_EN (frame gains a trailing even-parity bit).
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [n-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         en,
  output logic         sout,
  output logic         sout_valid,
  output logic         done
);

  localparam int unsigned CntW  = cnt_width(n);
  localparam int unsigned Frame = frame_len(n);

  state_e            state_q, state_d;
  logic [n-1:0]      sreg_q, sreg_d;
  logic              done_q, done_d;
  logic              cnt_clr, cnt_inc;
  logic [CntW-1:0]   count;
  logic              last;
  logic              bit_out;

  piso_bit_counter #(
    .Width   (CntW),
    .LastVal (Frame - 1)
  ) u_bit_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .count   (count),
    .last    (last)
  );

`ifdef PISO_PARITY_EN
  logic par_q;

  // Parity of the captured word, latched whenever a word is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_q <= 1'b0;
    end else if (load_valid && load_ready) begin
      par_q <= ^din;
    end
  end

  // The data register is empty by the parity slot, so substitute the parity bit.
  assign bit_out = last ? par_q : sreg_q[0];
`else
  assign bit_out = sreg_q[0];
`endif

  // State, shift register and done pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counter control and serial outputs.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        load_ready = 1'b1;
        if (load_valid) begin
          sreg_d  = din;
          cnt_clr = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        sout       = bit_out;
        sout_valid = 1'b1;
        if (en) begin
          sreg_d = {1'b0, sreg_q[n-1:1]};
          if (last) begin
            done_d     = 1'b1;
            cnt_clr    = 1'b1;
            load_ready = 1'b1;
            // Back-to-back capture keeps the line busy without a gap.
            if (load_valid) begin
              sreg_d = din;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: stimulus queues expected bits/words,
// a forked monitor pops and compares on every enabled valid bit.
module tb_piso_shift_tx;

  localparam int unsigned N     = 4;
  localparam int unsigned FRAME = piso_pkg::frame_len(N);

  logic         clock;
  logic         reset_n;
  logic [N-1:0] din;
  logic         load_valid;
  logic         load_ready;
  logic         en;
  logic         sout;
  logic         sout_valid;
  logic         done;

  int checks = 0;
  int errors = 0;
  bit done_pending = 1'b0;

  logic         exp_bits  [$];
  logic [N-1:0] exp_words [$];

  piso_shift_tx #(
    .n (N)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .en         (en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected serial bits of one frame, LSB first, plus parity when enabled.
  task automatic push_frame(input logic [N-1:0] w);
    logic [N-1:0] v;
    v = w;
    for (int i = 0; i < int'(N); i++) exp_bits.push_back(v[i]);
    if (FRAME > N) exp_bits.push_back(^v);
    exp_words.push_back(v);
  endtask

  task automatic monitor();
    logic [N-1:0] sipo;
    logic [N-1:0] ew;
    logic         eb;
    int           bitcnt;
    sipo   = '0;
    bitcnt = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        sipo         = '0;
        bitcnt       = 0;
        done_pending = 1'b0;
      end else begin
        if (done_pending) begin
          check("done_pulse", done, 1);
          done_pending = 1'b0;
        end else begin
          check("done_quiet", done, 0);
        end
        if (!sout_valid) begin
          check("idle_sout", sout, 0);
          check("idle_ready", load_ready, 1);
        end else if (en) begin
          if (exp_bits.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit: got %0b, expected no bit at %0t", sout, $time);
          end else begin
            eb = exp_bits.pop_front();
            check("sout_bit", sout, eb);
          end
          if (bitcnt < int'(N)) sipo = {sout, sipo[N-1:1]};
          bitcnt++;
          if (bitcnt == int'(FRAME)) begin
            if (exp_words.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_word: got %0h, expected none at %0t", sipo, $time);
            end else begin
              ew = exp_words.pop_front();
              check("sipo_word", sipo, ew);
            end
            done_pending = 1'b1;
            bitcnt       = 0;
          end
        end
      end
    end
  endtask

  initial begin
    logic [5:0] pat;
    reset_n    = 1'b0;
    din        = '0;
    load_valid = 1'b0;
    en         = 1'b0;
    fork
      monitor();
    join_none

    #1;
    check("rst_sout", sout, 0);
    check("rst_sout_valid", sout_valid, 0);
    check("rst_load_ready", load_ready, 1);
    check("rst_done", done, 0);
    step();
    step();
    reset_n = 1'b1;

    // Basic frame 1010.
    din = 4'b1010; load_valid = 1'b1; en = 1'b1;
    push_frame(4'b1010);
    step();
    load_valid = 1'b0;
    repeat (FRAME + 2) step();

    // Stalled frame 0110 with en pattern 1,0,1,1,0,1.
    din = 4'b0110; load_valid = 1'b1; en = 1'b0;
    push_frame(4'b0110);
    step();
    load_valid = 1'b0;
    pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      en = pat[i];
      step();
    end
    en = 1'b1;
    repeat (FRAME - 4 + 2) step();

    // Back-to-back frames 1010 then 0101.
    din = 4'b1010; load_valid = 1'b1; en = 1'b1;
    push_frame(4'b1010);
    step();
    din = 4'b0101;
    push_frame(4'b0101);
    repeat (FRAME - 1) begin
      check("b2b_busy_ready", load_ready, 0);
      check("b2b_valid1", sout_valid, 1);
      step();
    end
    check("b2b_last_ready", load_ready, 1);
    step();
    load_valid = 1'b0;
    repeat (FRAME) begin
      check("b2b_valid2", sout_valid, 1);
      step();
    end
    repeat (2) step();

    // Load attempt while busy is ignored.
    din = 4'b1001; load_valid = 1'b1; en = 1'b1;
    push_frame(4'b1001);
    step();
    load_valid = 1'b0;
    step();
    din = 4'b1111; load_valid = 1'b1;
    #1;
    check("busy_ready", load_ready, 0);
    step();
    load_valid = 1'b0; din = '0;
    repeat (FRAME + 1) step();

    // Reset after two bits of 1100.
    din = 4'b1100; load_valid = 1'b1; en = 1'b1;
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b0);
    step();
    load_valid = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_sout", sout, 0);
    check("mid_rst_valid", sout_valid, 0);
    check("mid_rst_ready", load_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_bits_used", exp_bits.size(), 0);
    step();
    reset_n = 1'b1;
    step();

    // Fresh frame after reset, then 1011 (parity 1 when enabled).
    din = 4'b0011; load_valid = 1'b1; en = 1'b1;
    push_frame(4'b0011);
    step();
    load_valid = 1'b0;
    repeat (FRAME + 2) step();
    din = 4'b1011; load_valid = 1'b1;
    push_frame(4'b1011);
    step();
    load_valid = 1'b0;
    repeat (FRAME + 3) step();

    check("bits_drained", exp_bits.size(), 0);
    check("words_drained", exp_words.size(), 0);
    check("no_done_pending", done_pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
